// File: rtl/duty_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : duty_button_conditioner
// Purpose  : Front end for the PWM duty-step inputs. Each raw push-button
//            level (increase / decrease) is synchronised, debounced and
//            turned into a single-cycle step pulse. Simultaneous requests
//            from both channels cancel each other, so the PWM stage never
//            sees both steps in the same cycle.
// Option   : DUTY_AUTO_REPEAT_EN - when defined, a held button issues
//            repeat requests after REPEAT_DELAY cycles, then one every
//            REPEAT_PERIOD cycles.
// Revision : 1.0 - initial release
// ============================================================================
module duty_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_level,
    output logic dec_level
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_DEB_PRESS   = 2'd1,
        S_PRESSED     = 2'd2,
        S_DEB_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam bit               c_deb_one  = (DEBOUNCE_CYCLES == 1);

    // Elaboration-time parameter sanity checks
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_chk_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_chk_rep
        $error("REPEAT_DELAY and REPEAT_PERIOD must be positive");
    end
`ifdef DUTY_AUTO_REPEAT_EN
    if (((64'd1 << CNT_W) <= 64'(REPEAT_DELAY)) ||
        ((64'd1 << CNT_W) <= 64'(REPEAT_PERIOD))) begin : g_chk_rep_w
        $error("CNT_W too narrow for REPEAT_DELAY / REPEAT_PERIOD");
    end
`endif

    // Channel 0 = increase, channel 1 = decrease
    logic [1:0] w_raw;
    logic [1:0] w_req_q;
    logic [1:0] w_level_q;

    assign w_raw = {btn_dec_raw, btn_inc_raw};

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic             r_sync1;
        logic             r_sync2;
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_qual_req;
        logic             w_rep_req;
        logic             w_fsm_level;
        logic             r_req;
        logic             r_req_q;
        logic             r_level_q;

        // Two-flop synchroniser on the asynchronous button level
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= w_raw[gi];
                r_sync2 <= r_sync1;
            end
        end

        // Debounce FSM state and stability counter
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // Debounce next-state: a level change is accepted only after
        // DEBOUNCE_CYCLES consecutive identical synchronised samples
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_qual_req  = 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (r_sync2) begin
                        if (c_deb_one) begin
                            w_state_nxt = S_PRESSED;
                            w_cnt_nxt   = '0;
                            w_qual_req  = 1'b1;
                        end else begin
                            w_state_nxt = S_DEB_PRESS;
                            w_cnt_nxt   = c_cnt_one;
                        end
                    end
                end
                S_DEB_PRESS: begin
                    if (!r_sync2) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_deb_last) begin
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = '0;
                        w_qual_req  = 1'b1;
                    end else if (r_cnt != '1) begin
                        w_cnt_nxt   = r_cnt + c_cnt_one;
                    end
                end
                S_PRESSED: begin
                    if (!r_sync2) begin
                        if (c_deb_one) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_DEB_RELEASE;
                            w_cnt_nxt   = c_cnt_one;
                        end
                    end
                end
                S_DEB_RELEASE: begin
                    if (r_sync2) begin
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_deb_last) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt != '1) begin
                        w_cnt_nxt   = r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_fsm_level = (r_state == S_PRESSED) || (r_state == S_DEB_RELEASE);

`ifdef DUTY_AUTO_REPEAT_EN
        localparam logic [CNT_W-1:0] c_rep_delay  = CNT_W'(REPEAT_DELAY);
        localparam logic [CNT_W-1:0] c_rep_period = CNT_W'(REPEAT_PERIOD);

        logic [CNT_W-1:0] r_hold;
        logic             r_rep_phase;
        logic             w_stay_pressed;
        logic             w_enter_pressed;
        logic [CNT_W-1:0] w_hold_target;

        assign w_stay_pressed  = (r_state == S_PRESSED) && r_sync2;
        assign w_enter_pressed = (r_state != S_PRESSED) && (w_state_nxt == S_PRESSED);
        assign w_hold_target   = r_rep_phase ? c_rep_period : c_rep_delay;
        assign w_rep_req       = w_stay_pressed && (r_hold == w_hold_target);

        // Hold timer: first wait is REPEAT_DELAY, later waits REPEAT_PERIOD;
        // restarts on every entry to PRESSED and clears when leaving it
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_hold      <= '0;
                r_rep_phase <= 1'b0;
            end else if (w_enter_pressed) begin
                r_hold      <= c_cnt_one;
                r_rep_phase <= 1'b0;
            end else if (w_stay_pressed) begin
                if (w_rep_req) begin
                    r_hold      <= c_cnt_one;
                    r_rep_phase <= 1'b1;
                end else if (r_hold != '1) begin
                    r_hold      <= r_hold + c_cnt_one;
                end
            end else begin
                r_hold      <= '0;
                r_rep_phase <= 1'b0;
            end
        end
`else
        assign w_rep_req = 1'b0;
`endif

        // Request register plus one retiming stage ahead of arbitration;
        // level travels alongside so it changes with the step pulse
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_req     <= 1'b0;
                r_req_q   <= 1'b0;
                r_level_q <= 1'b0;
            end else begin
                r_req     <= w_qual_req | w_rep_req;
                r_req_q   <= r_req;
                r_level_q <= w_fsm_level;
            end
        end

        assign w_req_q[gi]   = r_req_q;
        assign w_level_q[gi] = r_level_q;
    end

    // Registered arbitration: coincident requests are both dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            inc_level <= 1'b0;
            dec_level <= 1'b0;
        end else begin
            inc_pulse <= w_req_q[0] & ~w_req_q[1];
            dec_pulse <= w_req_q[1] & ~w_req_q[0];
            inc_level <= w_level_q[0];
            dec_level <= w_level_q[1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_duty_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_duty_button_conditioner
// Purpose  : Self-checking bench for duty_button_conditioner. Directed
//            scenarios followed by randomized button activity, compared each
//            cycle against a run-length debounce reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_duty_button_conditioner;

    localparam int c_deb     = 4;
    localparam int c_cnt_w   = 8;
    localparam int c_rdelay  = 20;
    localparam int c_rperiod = 8;
`ifdef DUTY_AUTO_REPEAT_EN
    localparam bit c_repeat  = 1'b1;
`else
    localparam bit c_repeat  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_inc_raw = 1'b0;
    logic btn_dec_raw = 1'b0;
    logic inc_pulse;
    logic dec_pulse;
    logic inc_level;
    logic dec_level;

    int n_cmp = 0;
    int n_err = 0;

    // Per-phase observation counters
    int ph_inc = 0;
    int ph_dec = 0;
    int ph_dec_fall = 0;
    logic prev_dec_level = 1'b0;

    duty_button_conditioner #(
        .DEBOUNCE_CYCLES (c_deb),
        .CNT_W           (c_cnt_w),
        .REPEAT_DELAY    (c_rdelay),
        .REPEAT_PERIOD   (c_rperiod)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .btn_inc_raw (btn_inc_raw),
        .btn_dec_raw (btn_dec_raw),
        .inc_pulse   (inc_pulse),
        .dec_pulse   (dec_pulse),
        .inc_level   (inc_level),
        .dec_level   (dec_level)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a channel's level flips once c_deb consecutive
    // synchronised samples disagree with it; outputs appear two edges
    // after the decision, both-channel requests cancel.
    // ------------------------------------------------------------------
    int m_s1[2], m_s2[2], m_lvl[2], m_run[2], m_since[2], m_req[2];
    int m_lv_d1[2], m_lv_d2[2], m_rq_d1[2], m_rq_d2[2];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0;    m_s2[c] = 0;    m_lvl[c] = 0;  m_run[c] = 0;
            m_since[c] = 0; m_req[c] = 0;   m_lv_d1[c] = 0; m_lv_d2[c] = 0;
            m_rq_d1[c] = 0; m_rq_d2[c] = 0;
        end
    endfunction

    function automatic void model_step();
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            int x;
            x = m_s2[c];
            m_lv_d2[c] = m_lv_d1[c];
            m_lv_d1[c] = m_lvl[c];
            m_rq_d2[c] = m_rq_d1[c];
            m_rq_d1[c] = m_req[c];
            m_req[c]   = 0;
            if (x != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] >= c_deb) begin
                    m_lvl[c]   = x;
                    m_run[c]   = 0;
                    m_since[c] = 0;
                    if (x == 1) m_req[c] = 1;
                end
            end else begin
                if (c_repeat && m_lvl[c] == 1 && m_run[c] == 0) begin
                    m_since[c]++;
                    if (m_since[c] == c_rdelay ||
                        (m_since[c] > c_rdelay && ((m_since[c] - c_rdelay) % c_rperiod) == 0))
                        m_req[c] = 1;
                end else begin
                    m_since[c] = 0;
                end
                m_run[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = (c == 0) ? int'(btn_inc_raw) : int'(btn_dec_raw);
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic compare_outputs();
        check("inc_pulse", 32'(inc_pulse), 32'(m_rq_d2[0] == 1 && m_rq_d2[1] == 0));
        check("dec_pulse", 32'(dec_pulse), 32'(m_rq_d2[1] == 1 && m_rq_d2[0] == 0));
        check("inc_level", 32'(inc_level), 32'(m_lv_d2[0]));
        check("dec_level", 32'(dec_level), 32'(m_lv_d2[1]));
        if (inc_pulse === 1'b1) ph_inc++;
        if (dec_pulse === 1'b1) ph_dec++;
        if (prev_dec_level === 1'b1 && dec_level === 1'b0) ph_dec_fall++;
        prev_dec_level = dec_level;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic drive(input logic inc, input logic dec, input int n);
        for (int i = 0; i < n; i++) begin
            btn_inc_raw = inc;
            btn_dec_raw = dec;
            step();
        end
    endtask

    // Asynchronous reset asserted between edges, checked immediately
    task automatic async_reset(input int hold);
        #2 rst = 1'b1;
        #1 model_reset();
        compare_outputs();
        for (int i = 0; i < hold; i++) step();
        rst = 1'b0;
    endtask

    task automatic clear_phase();
        ph_inc = 0;
        ph_dec = 0;
        ph_dec_fall = 0;
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        drive(1'b0, 1'b0, 3);
        rst = 1'b0;
        drive(1'b0, 1'b0, 4);

        // Simultaneous press: both levels rise, no pulses
        clear_phase();
        drive(1'b1, 1'b1, 15);
        check("simul_inc_pulses", 32'(ph_inc), 32'd0);
        check("simul_dec_pulses", 32'(ph_dec), 32'd0);
        check("simul_levels", {30'd0, inc_level, dec_level}, 32'd3);

        // Async reset with inputs high: outputs drop at once, stay low
        async_reset(10);
        drive(1'b0, 1'b0, 12);

        // Clean press held for 100 cycles: exactly one inc pulse
        clear_phase();
        drive(1'b1, 1'b0, 100);
        check("clean_inc_pulses", 32'(ph_inc), 32'd1);
        check("clean_dec_pulses", 32'(ph_dec), 32'd0);
        drive(1'b0, 1'b0, 12);

        // Bouncing press then release with a 2-cycle glitch
        clear_phase();
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 30);
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 15);
        check("bounce_dec_pulses", 32'(ph_dec), 32'd1);
        check("bounce_dec_falls", 32'(ph_dec_fall), 32'd1);

        // Reset mid-debounce: press must re-qualify from scratch
        clear_phase();
        drive(1'b1, 1'b0, 4);
        #2 rst = 1'b1;
        #1 model_reset();
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, 20);
        check("midreset_inc_pulses", 32'(ph_inc), 32'd1);
        drive(1'b0, 1'b0, 12);

        // Long hold: single pulse, or the repeat train when enabled
        clear_phase();
        drive(1'b1, 1'b0, 60);
        drive(1'b0, 1'b0, 15);
        check("hold_inc_pulses", 32'(ph_inc), c_repeat ? 32'd6 : 32'd1);

        // Randomized button activity with occasional async resets
        for (int seg = 0; seg < 400; seg++) begin
            logic r_inc, r_dec;
            int   len;
            r_inc = 1'($urandom_range(0, 1));
            r_dec = 1'($urandom_range(0, 3) == 0) ? ~r_inc : 1'($urandom_range(0, 1));
            len   = $urandom_range(1, 12);
            if ($urandom_range(0, 4) == 0) len = len + 25;
            drive(r_inc, r_dec, len);
            if ($urandom_range(0, 59) == 0) async_reset($urandom_range(1, 3));
        end
        drive(1'b0, 1'b0, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
